otp_ctrl_lci_prog: RTL and testbench
====================================

OTP_CTRL_LCI_PROG -- requirements
Module: otp_ctrl_lci_prog

Interface
REQ-001 SHALL have parameter NumWords, default 12, number of OTP words per life cycle transition (≥2).
REQ-002 SHALL have parameter WordWidth, default 16, native OTP word width in bits.
REQ-003 SHALL have parameter AddrWidth, default 11, OTP word address width.
REQ-004 SHALL have parameter BaseAddr, default 0, OTP word address of word 0.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk_i  in  1  clock.
REQ-007 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-008 SHALL have port lci_en_i  in  1  leave ResetSt.
REQ-009 SHALL have port escalate_i  in  1  escalation, forces terminal error.
REQ-010 SHALL have port lc_req_i  in  1  transition request.
REQ-011 SHALL have port lc_data_i  in  NumWords*WordWidth  target words, word i at bits [i*WordWidth +: WordWidth].
REQ-012 SHALL have port skip_zero_i  in  1  skip all-zero words, sampled with request.
REQ-013 SHALL have port lc_ack_o / lc_err_o  out  1 each  completion pulse / completion with error.
REQ-014 SHALL have port error_o  out  3  latched error code: 0 none, 1–5 OTP code, 6 VerifyError, 7 FsmStateError.
REQ-015 SHALL have port fsm_err_o  out  1  escalation or illegal-state pulse.
REQ-016 SHALL have port idle_o  out  1  high only in IdleSt.
REQ-017 SHALL have port words_done_o  out  $clog2(NumWords+1)  words completed or skipped in current transition.
REQ-018 SHALL have port otp_req_o, otp_cmd_o (1: 0 Read, 1 Write), otp_addr_o (AddrWidth), otp_wdata_o (WordWidth)  out  OTP request bus.
REQ-019 SHALL have port otp_gnt_i, otp_rvalid_i  in  1 each; otp_rdata_i  in  WordWidth; otp_err_i  in  3.

Function
REQ-020 States ResetSt, IdleSt, WriteSt, WriteWaitSt, ReadSt, ReadWaitSt, ErrorSt; any unlisted encoding → ErrorSt next cycle with fsm_err_o=1.
REQ-021 ResetSt → IdleSt when lci_en_i=1.
REQ-022 IdleSt with lc_req_i=1: latch lc_data_i and skip_zero_i into internal registers, clear word counter and words_done_o, go to WriteSt next cycle; lc_req_i ignored in all other states.
REQ-023 WriteSt: otp_req_o=1, otp_cmd_o=Write, otp_addr_o=BaseAddr+cnt (modulo 2^AddrWidth), otp_wdata_o=latched word[cnt]; held stable until otp_gnt_i, then WriteWaitSt.
REQ-024 WriteSt with skip latched and word[cnt]==0: otp_req_o=0, word counted as done in that cycle, no OTP access.
REQ-025 otp_wdata_o SHALL be zero whenever otp_req_o=0.
REQ-026 WriteWaitSt on otp_rvalid_i: a nonzero otp_err_i overwrites error_q; word complete (or proceeds to ReadSt, REQ-037).
REQ-027 Word completion: words_done_o increments; if cnt==NumWords-1 → finish, else cnt+1 and WriteSt.
REQ-028 Finish: lc_ack_o=1 for exactly one cycle; error_q==0 → IdleSt; otherwise lc_err_o=1 same cycle and → ErrorSt.
REQ-029 Errors do not abort: all remaining words are still attempted.
REQ-030 ErrorSt is terminal until reset; if error_q==0 there, error_q becomes 7.
REQ-031 escalate_i=1 in any state: → ErrorSt next cycle, fsm_err_o=1 that cycle, error_q becomes 7 only if currently 0, no lc_ack_o pulse.
REQ-032 Escalation in the same cycle as a finish SHALL win (no ack).

Reset
REQ-033 rst_i=1 at a clock edge: state ResetSt, error_q=0, counter and words_done_o 0, latched data 0.
REQ-034 During and after reset all outputs 0 (idle_o=0 in ResetSt); reset mid-transaction drops otp_req_o next cycle without waiting for gnt/rvalid.

Configuration
REQ-035 Macro OTP_CTRL_LCI_VERIFY_EN selects read-back verification.
REQ-036 Without it: ReadSt/ReadWaitSt unreachable; word completes on rvalid in WriteWaitSt.
REQ-037 With it: after WriteWaitSt rvalid → ReadSt (otp_cmd_o=Read, same address, held until gnt) → ReadWaitSt; on rvalid, otp_err_i≠0 latches that code, else otp_rdata_i≠word[cnt] latches 6; then word completes. Skipped words are not verified.

Verification
REQ-038 NumWords=4, all writes clean, no skip → 4 write grants, lc_ack_o one pulse, lc_err_o=0, IdleSt, words_done_o=4.
REQ-039 Word 1 returns otp_err_i=3 → words 2–3 still written, ack+err pulse together, error_o=3, ErrorSt.
REQ-040 skip_zero_i=1, words 0 and 2 zero → only addresses BaseAddr+1, +3 requested, words_done_o=4, ack.
REQ-041 escalate_i during WriteWaitSt → ErrorSt next cycle, fsm_err_o pulse, error_o=7, no ack.
REQ-042 VERIFY_EN, word 2 readback differs → error_o=6, ack+err, ErrorSt; without macro same stimulus → clean ack.
REQ-043 rst_i asserted while otp_req_o=1 awaiting gnt → otp_req_o=0 next cycle, state ResetSt, error_o=0.

Source files
------------

// File: rtl/otp_ctrl_lci_prog_if.sv
// rtl/otp_ctrl_lci_prog_if.sv - OTP request/response bus between the LCI programmer and the OTP macro
interface otp_ctrl_lci_prog_if #(
    parameter int WordWidth = 16,
    parameter int AddrWidth = 11
);
    logic                 otp_req_o;
    logic                 otp_cmd_o;
    logic [AddrWidth-1:0] otp_addr_o;
    logic [WordWidth-1:0] otp_wdata_o;
    logic                 otp_gnt_i;
    logic                 otp_rvalid_i;
    logic [WordWidth-1:0] otp_rdata_i;
    logic [2:0]           otp_err_i;

    modport master (
        output otp_req_o, otp_cmd_o, otp_addr_o, otp_wdata_o,
        input  otp_gnt_i, otp_rvalid_i, otp_rdata_i, otp_err_i
    );

    modport slave (
        input  otp_req_o, otp_cmd_o, otp_addr_o, otp_wdata_o,
        output otp_gnt_i, otp_rvalid_i, otp_rdata_i, otp_err_i
    );
endinterface

// File: rtl/otp_ctrl_lci_prog.sv
// rtl/otp_ctrl_lci_prog.sv - life cycle transition OTP word programmer; OTP_CTRL_LCI_VERIFY_EN adds read-back verify
module otp_ctrl_lci_prog #(
    parameter int          NumWords  = 12,
    parameter int          WordWidth = 16,
    parameter int          AddrWidth = 11,
    parameter int unsigned BaseAddr  = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          lci_en_i,
    input  logic                          escalate_i,
    input  logic                          lc_req_i,
    input  logic [NumWords*WordWidth-1:0] lc_data_i,
    input  logic                          skip_zero_i,
    output logic                          lc_ack_o,
    output logic                          lc_err_o,
    output logic [2:0]                    error_o,
    output logic                          fsm_err_o,
    output logic                          idle_o,
    output logic [$clog2(NumWords+1)-1:0] words_done_o,
    otp_ctrl_lci_prog_if.master           otp
);
    localparam int CntW  = $clog2(NumWords);
    localparam int DoneW = $clog2(NumWords+1);
    localparam logic [2:0] FsmStateError = 3'd7;

    typedef enum logic [2:0] {
        ResetSt     = 3'd0,
        IdleSt      = 3'd1,
        WriteSt     = 3'd2,
        WriteWaitSt = 3'd3,
        ReadSt      = 3'd4,
        ReadWaitSt  = 3'd5,
        ErrorSt     = 3'd6
    } state_e;

    state_e                        state_q;
    logic [NumWords*WordWidth-1:0] data_q;
    logic                          skip_q;
    logic [CntW-1:0]               cnt_q;
    logic [2:0]                    error_q;
    logic                          otp_req_q;
    logic                          otp_cmd_q;
    logic [AddrWidth-1:0]          otp_addr_q;
    logic [WordWidth-1:0]          otp_wdata_q;

    logic [WordWidth-1:0]          nxt_word;
    logic [WordWidth-1:0]          first_word;
    logic [CntW-1:0]               nxt_idx;
    logic                          last_word;
    logic                          word_done;
    logic [2:0]                    err_d;

    function automatic logic [WordWidth-1:0] word_at(input logic [NumWords*WordWidth-1:0] d,
                                                     input int idx);
        return d[idx*WordWidth +: WordWidth];
    endfunction

`ifdef OTP_CTRL_LCI_VERIFY_EN
    logic [WordWidth-1:0] cur_word;
    assign cur_word = word_at(data_q, int'(cnt_q));
`else
    logic unused_rdata;
    assign unused_rdata = ^otp.otp_rdata_i;
`endif

    // Response handling: err_d is the error code after this cycle's OTP response, word_done ends a word.
    always_comb begin
        first_word = word_at(lc_data_i, 0);
        last_word  = (cnt_q == CntW'(NumWords-1));
        nxt_idx    = last_word ? '0 : cnt_q + CntW'(1);
        nxt_word   = word_at(data_q, int'(nxt_idx));
        err_d      = error_q;
        word_done  = 1'b0;
        case (state_q)
            WriteSt: word_done = !otp_req_q;
            WriteWaitSt: begin
                if (otp.otp_rvalid_i) begin
                    if (otp.otp_err_i != 3'd0) err_d = otp.otp_err_i;
`ifndef OTP_CTRL_LCI_VERIFY_EN
                    word_done = 1'b1;
`endif
                end
            end
`ifdef OTP_CTRL_LCI_VERIFY_EN
            ReadWaitSt: begin
                if (otp.otp_rvalid_i) begin
                    if (otp.otp_err_i != 3'd0)         err_d = otp.otp_err_i;
                    else if (otp.otp_rdata_i != cur_word) err_d = 3'd6;
                    word_done = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        lc_ack_o  <= 1'b0;
        lc_err_o  <= 1'b0;
        fsm_err_o <= 1'b0;
        idle_o    <= 1'b0;
        if (rst_i) begin
            state_q      <= ResetSt;
            data_q       <= '0;
            skip_q       <= 1'b0;
            cnt_q        <= '0;
            words_done_o <= '0;
            error_q      <= '0;
            otp_req_q    <= 1'b0;
            otp_cmd_q    <= 1'b0;
            otp_addr_q   <= '0;
            otp_wdata_q  <= '0;
        end else if (escalate_i) begin
            state_q     <= ErrorSt;
            fsm_err_o   <= 1'b1;
            otp_req_q   <= 1'b0;
            otp_wdata_q <= '0;
            if (error_q == 3'd0) error_q <= FsmStateError;
        end else begin
            error_q <= err_d;
            case (state_q)
                ResetSt: begin
                    if (lci_en_i) begin
                        state_q <= IdleSt;
                        idle_o  <= 1'b1;
                    end
                end
                IdleSt: begin
                    if (lc_req_i) begin
                        data_q       <= lc_data_i;
                        skip_q       <= skip_zero_i;
                        cnt_q        <= '0;
                        words_done_o <= '0;
                        state_q      <= WriteSt;
                        // A skipped word enters WriteSt with the request already low.
                        otp_req_q    <= !(skip_zero_i && first_word == '0);
                        otp_cmd_q    <= 1'b1;
                        otp_addr_q   <= AddrWidth'(BaseAddr);
                        otp_wdata_q  <= first_word;
                    end else begin
                        idle_o <= 1'b1;
                    end
                end
                WriteSt: begin
                    if (otp_req_q && otp.otp_gnt_i) begin
                        otp_req_q   <= 1'b0;
                        otp_wdata_q <= '0;
                        state_q     <= WriteWaitSt;
                    end
                end
`ifdef OTP_CTRL_LCI_VERIFY_EN
                WriteWaitSt: begin
                    if (otp.otp_rvalid_i) begin
                        state_q   <= ReadSt;
                        otp_req_q <= 1'b1;
                        otp_cmd_q <= 1'b0;
                    end
                end
                ReadSt: begin
                    if (otp.otp_gnt_i) begin
                        otp_req_q <= 1'b0;
                        state_q   <= ReadWaitSt;
                    end
                end
                ReadWaitSt: ;
`else
                WriteWaitSt: ;
`endif
                ErrorSt: begin
                    if (error_q == 3'd0) error_q <= FsmStateError;
                end
                default: begin
                    state_q     <= ErrorSt;
                    fsm_err_o   <= 1'b1;
                    otp_req_q   <= 1'b0;
                    otp_wdata_q <= '0;
                end
            endcase

            if (word_done) begin
                words_done_o <= words_done_o + DoneW'(1);
                if (last_word) begin
                    lc_ack_o    <= 1'b1;
                    otp_req_q   <= 1'b0;
                    otp_wdata_q <= '0;
                    if (err_d != 3'd0) begin
                        lc_err_o <= 1'b1;
                        state_q  <= ErrorSt;
                    end else begin
                        idle_o  <= 1'b1;
                        state_q <= IdleSt;
                    end
                end else begin
                    cnt_q       <= nxt_idx;
                    state_q     <= WriteSt;
                    otp_req_q   <= !(skip_q && nxt_word == '0);
                    otp_cmd_q   <= 1'b1;
                    otp_addr_q  <= AddrWidth'(BaseAddr) + AddrWidth'(nxt_idx);
                    otp_wdata_q <= nxt_word;
                end
            end
        end
    end

    assign error_o         = error_q;
    assign otp.otp_req_o   = otp_req_q;
    assign otp.otp_cmd_o   = otp_cmd_q;
    assign otp.otp_addr_o  = otp_addr_q;
    assign otp.otp_wdata_o = otp_wdata_q;
endmodule

// File: tb/tb_otp_ctrl_lci_prog.sv
// tb/tb_otp_ctrl_lci_prog.sv - self-checking bench for otp_ctrl_lci_prog with a behavioural OTP and outcome model
module tb_otp_ctrl_lci_prog;
    localparam int          NW   = 4;
    localparam int          WW   = 16;
    localparam int          AW   = 11;
    localparam int unsigned BASE = 2046;
`ifdef OTP_CTRL_LCI_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_i, lci_en_i, escalate_i, lc_req_i, skip_zero_i;
    logic [NW*WW-1:0] lc_data_i;
    logic           lc_ack_o, lc_err_o, fsm_err_o, idle_o;
    logic [2:0]     error_o;
    logic [2:0]     words_done_o;

    otp_ctrl_lci_prog_if #(.WordWidth(WW), .AddrWidth(AW)) otp ();

    otp_ctrl_lci_prog #(
        .NumWords (NW),
        .WordWidth(WW),
        .AddrWidth(AW),
        .BaseAddr (BASE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .lci_en_i    (lci_en_i),
        .escalate_i  (escalate_i),
        .lc_req_i    (lc_req_i),
        .lc_data_i   (lc_data_i),
        .skip_zero_i (skip_zero_i),
        .lc_ack_o    (lc_ack_o),
        .lc_err_o    (lc_err_o),
        .error_o     (error_o),
        .fsm_err_o   (fsm_err_o),
        .idle_o      (idle_o),
        .words_done_o(words_done_o),
        .otp         (otp)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    // Transaction description and observations
    logic [WW-1:0] tw   [NW];
    logic [2:0]    terr [NW];
    bit            tskip;
    int            tcorrupt;
    int            tesc;
    bit            tesc_last;
    int            n_wr, n_ack, n_ackerr, n_fsm, n_exp_wr;
    bit            escalated;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; lci_en_i = 1'b1; escalate_i = 1'b0; lc_req_i = 1'b0;
        skip_zero_i = 1'b0; lc_data_i = '0;
        otp.otp_gnt_i = 1'b0; otp.otp_rvalid_i = 1'b0; otp.otp_err_i = '0; otp.otp_rdata_i = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset_en();
        do_reset();
        rst_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_txn();
        for (int i = 0; i < NW; i++) begin
            tw[i]   = WW'($urandom_range(1, 65535));
            terr[i] = '0;
        end
        tskip = 1'b0; tcorrupt = -1; tesc = -1; tesc_last = 1'b0;
    endtask

    // Final error code: the last nonzero code among the responses to words actually attempted
    function automatic logic [2:0] model_err();
        logic [2:0] e;
        e = '0;
        for (int i = 0; i < NW; i++) begin
            if (!(tskip && tw[i] == '0)) begin
                if (terr[i] != '0) e = terr[i];
                if (VERIFY && i == tcorrupt) e = 3'd6;
            end
        end
        return e;
    endfunction

    task automatic run_txn();
        logic [AW-1:0] exp_addr [$];
        logic [WW-1:0] mem [NW];
        logic [AW-1:0] a, last_wr;
        int  delay, idx, post_esc, wr_k;
        bit  pending, pend_rd, fin;
        delay = 0; idx = 0; post_esc = 0; wr_k = 0;
        pending = 1'b0; pend_rd = 1'b0; fin = 1'b0; last_wr = '0;
        n_wr = 0; n_ack = 0; n_ackerr = 0; n_fsm = 0; escalated = 1'b0;
        for (int i = 0; i < NW; i++) begin
            mem[i] = '0;
            if (!(tskip && tw[i] == '0)) exp_addr.push_back(AW'(BASE + i));
            lc_data_i[i*WW +: WW] = tw[i];
        end
        n_exp_wr    = exp_addr.size();
        skip_zero_i = tskip;
        lc_req_i    = 1'b1;
        @(negedge clk);
        lc_req_i    = 1'b0;
        lc_data_i   = {$urandom, $urandom};
        skip_zero_i = ~tskip;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            otp.otp_gnt_i = 1'b0; otp.otp_rvalid_i = 1'b0; otp.otp_err_i = '0;
            otp.otp_rdata_i = WW'($urandom); escalate_i = 1'b0;
            if (!otp.otp_req_o) chk("wdata_zero_when_idle", 32'(otp.otp_wdata_o), 0);
            if (lc_err_o && !lc_ack_o) chk("lc_err_without_ack", 1, 0);
            if (lc_ack_o) begin
                n_ack++;
                if (lc_err_o) n_ackerr++;
                fin = 1'b1;
            end
            if (fsm_err_o) n_fsm++;
            if (escalated) begin
                post_esc++;
                if (post_esc > 8) fin = 1'b1;
            end else if (pending) begin
                if (tesc >= 0 && !pend_rd && n_wr == tesc + 1) begin
                    escalate_i = 1'b1; escalated = 1'b1;
                end else if (delay > 0) begin
                    delay--;
                end else begin
                    otp.otp_rvalid_i = 1'b1;
                    pending = 1'b0;
                    if (pend_rd) otp.otp_rdata_i = (idx == tcorrupt) ? ~mem[idx] : mem[idx];
                    else         otp.otp_err_i   = terr[idx];
                    if (tesc_last && idx == NW-1 && (pend_rd == VERIFY)) begin
                        escalate_i = 1'b1; escalated = 1'b1;
                    end
                end
            end else if (otp.otp_req_o && $urandom_range(0, 2) != 0) begin
                otp.otp_gnt_i = 1'b1;
                pending = 1'b1;
                delay   = $urandom_range(0, 2);
                a       = otp.otp_addr_o;
                idx     = int'(AW'(a - AW'(BASE)));
                pend_rd = !otp.otp_cmd_o;
                if (otp.otp_cmd_o) begin
                    if (wr_k < n_exp_wr) chk("write_addr", 32'(a), 32'(exp_addr[wr_k]));
                    else                 chk("extra_write", 1, 0);
                    if (idx >= NW) idx = 0;
                    chk("write_data", 32'(otp.otp_wdata_o), 32'(tw[idx]));
                    mem[idx] = otp.otp_wdata_o;
                    last_wr  = a;
                    n_wr++; wr_k++;
                end else begin
                    chk("read_addr", 32'(a), 32'(last_wr));
                    if (idx >= NW) idx = 0;
                end
            end
            if (!fin) @(negedge clk);
        end
        otp.otp_gnt_i = 1'b0; otp.otp_rvalid_i = 1'b0; otp.otp_err_i = '0; escalate_i = 1'b0;
        if (!fin) chk("txn_timeout", 1, 0);
    endtask

    task automatic check_outcome();
        logic [2:0] e;
        e = model_err();
        if (tesc >= 0 || tesc_last) begin
            chk("esc_no_ack", n_ack, 0);
            chk("esc_fsm_err_pulses", n_fsm, 1);
            chk("esc_error_code", 32'(error_o), 7);
            chk("esc_not_idle", 32'(idle_o), 0);
        end else begin
            chk("write_count", n_wr, n_exp_wr);
            chk("ack_pulses", n_ack, 1);
            chk("ack_with_err", n_ackerr, 32'(e != '0));
            chk("error_code", 32'(error_o), 32'(e));
            chk("idle_after", 32'(idle_o), 32'(e == '0));
            chk("words_done", 32'(words_done_o), NW);
            chk("no_fsm_err", n_fsm, 0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset state, with lci_en_i held high to show reset dominates
        do_reset();
        chk("rst_ack", 32'(lc_ack_o), 0);
        chk("rst_lc_err", 32'(lc_err_o), 0);
        chk("rst_error", 32'(error_o), 0);
        chk("rst_fsm_err", 32'(fsm_err_o), 0);
        chk("rst_idle", 32'(idle_o), 0);
        chk("rst_words_done", 32'(words_done_o), 0);
        chk("rst_req", 32'(otp.otp_req_o), 0);
        chk("rst_addr", 32'(otp.otp_addr_o), 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_after_enable", 32'(idle_o), 1);

        // Clean transaction, then a back-to-back second one
        clear_txn(); run_txn(); check_outcome();
        clear_txn(); run_txn(); check_outcome();

        // Word 1 error 3, remaining words still written
        do_reset_en(); clear_txn(); terr[1] = 3'd3; run_txn(); check_outcome();

        // Skip zero words 0 and 2; addresses wrap past 2^AddrWidth
        do_reset_en(); clear_txn(); tw[0] = '0; tw[2] = '0; tskip = 1'b1; run_txn(); check_outcome();

        // Zero words written when skip is off
        do_reset_en(); clear_txn(); tw[1] = '0; tw[3] = '0; run_txn(); check_outcome();

        // Escalation while waiting for word 1's write response
        do_reset_en(); clear_txn(); tesc = 1; run_txn(); check_outcome();
        chk("esc_words_done", 32'(words_done_o), 1);
        lc_req_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("error_state_ignores_req", 32'(otp.otp_req_o), 0);
        end
        lc_req_i = 1'b0;

        // Read-back of word 2 differs (only an error when verification is built in)
        do_reset_en(); clear_txn(); tcorrupt = 2; run_txn(); check_outcome();

        // Escalation coinciding with the final response wins over the ack
        do_reset_en(); clear_txn(); tesc_last = 1'b1; run_txn(); check_outcome();

        // Randomised transactions
        for (int t = 0; t < 8; t++) begin
            do_reset_en();
            clear_txn();
            for (int i = 0; i < NW; i++) begin
                tw[i]   = ($urandom_range(0, 2) == 0) ? '0 : WW'($urandom);
                terr[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 5)) : 3'd0;
            end
            tskip    = 1'($urandom_range(0, 1));
            tcorrupt = int'($urandom_range(0, 5));
            run_txn();
            check_outcome();
        end

        // Reset while a request is waiting for its grant
        do_reset_en(); clear_txn();
        for (int i = 0; i < NW; i++) lc_data_i[i*WW +: WW] = tw[i];
        lc_req_i = 1'b1;
        @(negedge clk);
        lc_req_i = 1'b0;
        otp.otp_gnt_i = 1'b1;
        @(negedge clk);
        otp.otp_gnt_i = 1'b0;
        otp.otp_rvalid_i = 1'b1;
        otp.otp_err_i = 3'd2;
        @(negedge clk);
        otp.otp_rvalid_i = 1'b0;
        otp.otp_err_i = '0;
        chk("req_before_reset", 32'(otp.otp_req_o), 1);
        chk("error_before_reset", 32'(error_o), 2);
        rst_i = 1'b1;
        @(negedge clk);
        chk("reset_drops_req", 32'(otp.otp_req_o), 0);
        chk("reset_clears_error", 32'(error_o), 0);
        chk("reset_clears_done", 32'(words_done_o), 0);
        chk("reset_not_idle", 32'(idle_o), 0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_after_reset", 32'(idle_o), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
